// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage plus the IF/ID pipeline register.
//   - Owns the fetch PC and drives the instruction ROM address straight from it.
//   - Latches {pc, pc+4, instruction, valid} for the decode stage.
//   - Load-use stall holds PC and IF/ID; an EX-resolved redirect overrides a
//     stall, reloads the PC and replaces the IF/ID contents with a bubble.
//   - Saturating stall / flush event counters for performance debug.
//
//   Handshake: there is no valid/ready pair here. The hazard unit's
//   load_use_stall_flag acts as an inverted ready for the whole stage (1 =
//   downstream not accepting, hold everything), valid_o qualifies the IF/ID
//   payload, and jump_flag is a single-cycle command sampled on the rising edge.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_use_stall_flag,
    input  logic              jump_flag,
    input  logic [31:0]       jump_target,
    input  logic [31:0]       imem_inst,
    output logic [31:0]       imem_addr,
    output logic [31:0]       pc_o,
    output logic [31:0]       npc_pc4_o,
    output logic [31:0]       inst_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // Word alignment mask applied to redirect targets.
    localparam logic [31:0] ALIGN_MASK = ~32'h0000_0003;
    localparam logic [31:0] PC_STEP    = 32'h0000_0004;

    // -----------------------------------------------------------------------
    // State registers and their next-state values
    // -----------------------------------------------------------------------
    logic [31:0]      pc_q,        pc_d;
    logic [31:0]      id_pc_q,     id_pc_d;
    logic [31:0]      id_npc_q,    id_npc_d;
    logic [31:0]      id_inst_q,   id_inst_d;
    logic             id_valid_q,  id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Decoded per-cycle action; redirect has priority over stall.
    logic do_redirect;
    logic do_stall;
    logic do_advance;

    // Sequential PC successor, modulo 2^32 (0xFFFF_FFFC wraps to 0).
    logic [31:0] pc_plus4;

    // Counter saturation detect.
    logic stall_cnt_full;
    logic flush_cnt_full;

    // Classify the current cycle into exactly one action.
    always_comb begin
        do_redirect = jump_flag;
        do_stall    = load_use_stall_flag & ~jump_flag;
        do_advance  = ~load_use_stall_flag & ~jump_flag;
    end

    // PC successor and counter saturation flags.
    always_comb begin
        pc_plus4       = pc_q + PC_STEP;
        stall_cnt_full = &stall_cnt_q;
        flush_cnt_full = &flush_cnt_q;
    end

    // Next PC: redirect target, hold, or sequential.
    always_comb begin
        pc_d = pc_q;
        if (do_redirect) begin
            pc_d = jump_target & ALIGN_MASK;
        end else if (do_advance) begin
            pc_d = pc_plus4;
        end
    end

    // Next IF/ID contents: bubble on redirect, hold on stall, new fetch otherwise.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_npc_d   = id_npc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        if (do_redirect) begin
            id_pc_d    = 32'h0000_0000;
            id_npc_d   = 32'h0000_0000;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end else if (do_advance) begin
            id_pc_d    = pc_q;
            id_npc_d   = pc_plus4;
            id_inst_d  = imem_inst;
            id_valid_d = 1'b1;
        end
    end

    // Next performance counter values; each saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (do_stall && !stall_cnt_full) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (do_redirect && !flush_cnt_full) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Fetch PC register; reset loads the boot address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // IF/ID pipeline register; reset leaves a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc_q    <= 32'h0000_0000;
            id_npc_q   <= 32'h0000_0000;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
        end else begin
            id_pc_q    <= id_pc_d;
            id_npc_q   <= id_npc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    // Stall / flush event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Outputs come straight from registers; the ROM address is the PC itself.
    always_comb begin
        imem_addr   = pc_q;
        pc_o        = id_pc_q;
        npc_pc4_o   = id_npc_q;
        inst_o      = id_inst_q;
        valid_o     = id_valid_q;
        stall_cnt_o = stall_cnt_q;
        flush_cnt_o = flush_cnt_q;
    end

endmodule
